// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed digit display.
package display_pkg;

    localparam int          BCD_W            = 4;
    localparam int          DEFAULT_N_DIGITS = 4;
    // All digit enables released (active-low); slice to the digit count in use.
    localparam logic [31:0] AN_ALL_OFF       = '1;

    // Width of a slot index; a single-digit display still needs one bit.
    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_mux_tick_divider.sv
// Modulo-DIV counter with enable; wrap_o flags the enabled cycle that rolls over.
module tick_divider #(
    parameter int DIV = 4,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(DIV - 1);

    assign wrap_o = en_i && (cnt_o == LAST);

    // Count enabled cycles, returning to zero after DIV of them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_o <= '0;
        else if (wrap_o) cnt_o <= '0;
        else if (en_i)   cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Scans latched BCD digits onto one shared bus with active-low digit enables,
// leading-zero blanking, per-digit blink, decimal points and dead time.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int N_DIGITS    = DEFAULT_N_DIGITS,
    parameter int CLK_DIV     = 1000,
    parameter int DEAD_CYCLES = 1,
    parameter int BLINK_DIV   = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BCD_W*N_DIGITS-1:0]     digits_i,
    input  logic [N_DIGITS-1:0]           blink_mask_i,
    input  logic                          lz_blank_i,
    input  logic [N_DIGITS-1:0]           dp_mask_i,
    output logic [BCD_W-1:0]              bcd_o,
    output logic [N_DIGITS-1:0]           an_o,
    output logic                          dp_o,
    output logic [slot_w(N_DIGITS)-1:0]   slot_o,
    output logic                          frame_tick_o
);

    localparam int SW = slot_w(N_DIGITS);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] LAST_SLOT = SW'(N_DIGITS - 1);
    localparam logic [DW-1:0] DEAD_END  = DW'(DEAD_CYCLES);

    logic [DW-1:0]                      div_cnt;
    logic                               div_wrap;
    logic [FW-1:0]                      frame_cnt;
    logic                               blink_wrap;
    logic [SW-1:0]                      slot;
    logic                               blink_phase;
    logic                               frame_end;

    logic [N_DIGITS-1:0][BCD_W-1:0]     lat_digits;
    logic [N_DIGITS-1:0]                lat_blink;
    logic                               lat_lz;
    logic [N_DIGITS-1:0]                lat_dp;

    logic                               blanked;
    logic                               lit;

    tick_divider #(.DIV(CLK_DIV), .W(DW)) u_slot_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (1'b1),
        .cnt_o  (div_cnt),
        .wrap_o (div_wrap)
    );

    assign frame_end = div_wrap && (slot == LAST_SLOT);

    // Blink half-period counted in whole frames.
    tick_divider #(.DIV(BLINK_DIV), .W(FW)) u_frame_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (frame_end),
        .cnt_o  (frame_cnt),
        .wrap_o (blink_wrap)
    );

    // Slot advance, blink toggle, and frame-coherent input capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot        <= '0;
            blink_phase <= 1'b0;
            lat_digits  <= '0;
            lat_blink   <= '0;
            lat_lz      <= 1'b0;
            lat_dp      <= '0;
        end else begin
            if (div_wrap)   slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
            if (blink_wrap) blink_phase <= ~blink_phase;
            if (frame_end) begin
                lat_digits <= digits_i;
                lat_blink  <= blink_mask_i;
                lat_lz     <= lz_blank_i;
                lat_dp     <= dp_mask_i;
            end
        end
    end

    // Output decode from registered state. rst_n gates the enables so the
    // display goes dark the instant reset asserts, even with zero dead time.
    always_comb begin
        blanked = (lat_blink[slot] && blink_phase) ||
                  ((slot == LAST_SLOT) && lat_lz && (lat_digits[N_DIGITS-1] == '0));
        lit     = rst_n && (div_cnt >= DEAD_END) && !blanked;

        an_o = AN_ALL_OFF[N_DIGITS-1:0];
        if (lit) an_o[slot] = 1'b0;

        dp_o         = !(lit && lat_dp[slot]);
        bcd_o        = lat_digits[slot];
        slot_o       = slot;
        frame_tick_o = frame_end;
    end

endmodule
